// File: rtl/rs_pkg.sv
// rs_pkg: unit-tag base constants and a constant-foldable clog2 shared by the reservation-station bank
package rs_pkg;
  localparam logic [7:0] TAG_SW = 8'h00, TAG_ADD = 8'h20, TAG_MUL = 8'h40, TAG_VALUE_PRESENT = 8'h7F, TAG_LW = 8'h80;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rs_pick.sv
// rs_pick: N-wide one-of selector (req -> one-hot gnt, idx, any); lowest index wins, or with RS_AGE_ORDER_EN and AGED=1 the smallest age-base modulo N
module rs_pick import rs_pkg::*; #(
  parameter int N = 8
`ifdef RS_AGE_ORDER_EN
  , parameter bit AGED = 1'b0
`endif
) (
  input  logic [N-1:0]             req,
`ifdef RS_AGE_ORDER_EN
  input  logic [N-1:0][clog2(N)-1:0] age,
  input  logic [clog2(N)-1:0]      base,
`endif
  output logic [N-1:0]             gnt,
  output logic [clog2(N)-1:0]      idx,
  output logic                     any
);
  localparam int IW = clog2(N);
  logic [IW-1:0] key, best;
  always_comb begin
    any = 1'b0;
    idx = '0;
    best = '0;
    key = '0;
    for (int i = 0; i < N; i++) begin
`ifdef RS_AGE_ORDER_EN
      key = AGED ? age[i] - base : IW'(i);
`else
      key = IW'(i);
`endif
      if (req[i] && (!any || key < best)) begin
        any = 1'b1;
        idx = IW'(i);
        best = key;
      end
    end
  end
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/rs_bank.sv
// rs_bank: reservation-station bank (dispatch in, CDB wake-up, issue out, flush; count = occupancy); RS_AGE_ORDER_EN selects oldest-ready issue instead of lowest index
module rs_bank import rs_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int NSRC = 2,
  parameter int WORD_W = 32,
  parameter int TAG_W = 8,
  parameter logic [TAG_W-1:0] TAG_BASE = TAG_W'(TAG_ADD)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [NSRC-1:0]            disp_src_rdy,
  input  logic [NSRC*TAG_W-1:0]      disp_src_tag,
  input  logic [NSRC*WORD_W-1:0]     disp_src_val,
  output logic [TAG_W-1:0]           disp_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [WORD_W-1:0]          cdb_val,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [NSRC*WORD_W-1:0]     iss_src,
  output logic [TAG_W-1:0]           iss_tag,
  output logic [clog2(DEPTH+1)-1:0]  count
);
  localparam int IW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  typedef struct packed {
    logic rdy;
    logic [TAG_W-1:0] tag;
    logic [WORD_W-1:0] val;
  } src_t;
  logic [DEPTH-1:0] busy, ready, free_gnt, iss_gnt;
  src_t src [DEPTH][NSRC];
  src_t din [NSRC];
  logic [IW-1:0] free_idx, iss_idx;
  logic free_any, iss_any, hold, disp_fire, iss_fire;
`ifdef RS_AGE_ORDER_EN
  logic [DEPTH-1:0][IW-1:0] age;
  logic [IW-1:0] stamp;
`endif
  assign hold = rst || flush;
  always_comb begin
    ready = '0;
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy[i];
      for (int j = 0; j < NSRC; j++) ready[i] = ready[i] && src[i][j].rdy;
      count = count + CW'(busy[i]);
    end
  end
  rs_pick #(
    .N(DEPTH)
`ifdef RS_AGE_ORDER_EN
    , .AGED(1'b0)
`endif
  ) u_free (
    .req(~busy),
`ifdef RS_AGE_ORDER_EN
    .age('0),
    .base('0),
`endif
    .gnt(free_gnt),
    .idx(free_idx),
    .any(free_any)
  );
  rs_pick #(
    .N(DEPTH)
`ifdef RS_AGE_ORDER_EN
    , .AGED(1'b1)
`endif
  ) u_iss (
    .req(ready),
`ifdef RS_AGE_ORDER_EN
    .age(age),
    .base(stamp),
`endif
    .gnt(iss_gnt),
    .idx(iss_idx),
    .any(iss_any)
  );
  assign disp_ready = free_any;
  assign disp_tag = hold ? '0 : TAG_BASE + TAG_W'(free_idx);
  assign iss_valid = !hold && iss_any;
  assign iss_tag = iss_valid ? TAG_BASE + TAG_W'(iss_idx) : '0;
  assign disp_fire = disp_valid && disp_ready && !hold;
  assign iss_fire = iss_valid && iss_ready;
  always_comb begin
    iss_src = '0;
    for (int j = 0; j < NSRC; j++) begin
      iss_src[j*WORD_W +: WORD_W] = iss_valid ? src[iss_idx][j].val : '0;
      din[j].tag = disp_src_tag[j*TAG_W +: TAG_W];
      din[j].rdy = disp_src_rdy[j] || (cdb_valid && din[j].tag == cdb_tag);
      din[j].val = disp_src_rdy[j] ? disp_src_val[j*WORD_W +: WORD_W] : cdb_val;
    end
  end
  always_ff @(posedge clk) begin
    if (hold) busy <= '0;
    else busy <= (busy & ~({DEPTH{iss_fire}} & iss_gnt)) | ({DEPTH{disp_fire}} & free_gnt);
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < NSRC; j++)
        if (disp_fire && free_gnt[i]) src[i][j] <= din[j];
        else if (cdb_valid && busy[i] && !src[i][j].rdy && src[i][j].tag == cdb_tag)
          src[i][j] <= '{rdy: 1'b1, tag: src[i][j].tag, val: cdb_val};
  end
`ifdef RS_AGE_ORDER_EN
  always_ff @(posedge clk) begin
    if (hold) stamp <= '0;
    else if (disp_fire) begin
      stamp <= stamp + 1'b1;
      age[free_idx] <= stamp;
    end
  end
`endif
  always_ff @(posedge clk) if (!rst) assert (count <= CW'(DEPTH));
endmodule

// File: tb/tb_rs_bank.sv
// tb_rs_bank: randomized scoreboard bench for rs_bank against a slot-array reference model
module tb_rs_bank;
  localparam int D = 8, NS = 2, W = 32, TW = 8;
  localparam logic [7:0] BASE = 8'h20;
  logic clk = 1'b0;
  logic rst, flush, disp_valid, disp_ready, cdb_valid, iss_valid, iss_ready;
  logic [NS-1:0] disp_src_rdy;
  logic [NS*TW-1:0] disp_src_tag;
  logic [NS*W-1:0] disp_src_val, iss_src;
  logic [TW-1:0] disp_tag, cdb_tag, iss_tag;
  logic [W-1:0] cdb_val;
  logic [3:0] count;
  always #5 clk = ~clk;
  rs_bank #(.DEPTH(D), .NSRC(NS), .WORD_W(W), .TAG_W(TW), .TAG_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_src_rdy(disp_src_rdy),
    .disp_src_tag(disp_src_tag), .disp_src_val(disp_src_val), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_src(iss_src), .iss_tag(iss_tag),
    .count(count)
  );
  typedef struct {
    logic dr, chk_dt, iv;
    logic [7:0] dt, it;
    logic [63:0] srcv;
    logic [3:0] cnt;
  } exp_t;
  typedef struct {
    logic [7:0] tag;
    logic [63:0] srcv;
  } iss_t;
  exp_t eq[$];
  iss_t iq[$];
  int compared = 0, mismatched = 0;
  bit mb [D];
  bit mr [D][NS];
  logic [7:0] mt [D][NS];
  logic [31:0] mv [D][NS];
  int ms [D];
  int seq = 0;
  logic [7:0] pool [5] = '{8'h40, 8'h41, 8'h42, 8'h80, 8'h81};
  function automatic logic [7:0] ptag();
    return pool[$urandom_range(0, 4)];
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask
  task automatic cyc(input bit r, input bit fl, input bit dv, input logic [1:0] sr,
                     input logic [7:0] t0, input logic [7:0] t1, input logic [31:0] v0, input logic [31:0] v1,
                     input bit cv, input logic [7:0] ct, input logic [31:0] cval, input bit ir);
    exp_t x;
    int fr, sel, n;
    bit gate;
    @(negedge clk);
    rst = r; flush = fl; disp_valid = dv; disp_src_rdy = sr;
    disp_src_tag = {t1, t0}; disp_src_val = {v1, v0};
    cdb_valid = cv; cdb_tag = ct; cdb_val = cval; iss_ready = ir;
    #1;
    gate = r || fl; fr = -1; sel = -1; n = 0;
    for (int i = 0; i < D; i++) begin
      if (!mb[i] && fr < 0) fr = i;
      if (mb[i]) n++;
      if (mb[i] && mr[i][0] && mr[i][1]) begin
`ifdef RS_AGE_ORDER_EN
        if (sel < 0 || ms[i] < ms[sel]) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    x.dr = fr >= 0;
    x.chk_dt = gate || fr >= 0;
    x.dt = gate ? 8'h00 : BASE + 8'(fr);
    x.iv = !gate && sel >= 0;
    x.it = 8'h00;
    x.srcv = 64'h0;
    if (x.iv) begin
      x.it = BASE + 8'(sel);
      x.srcv = {mv[sel][1], mv[sel][0]};
    end
    x.cnt = 4'(n);
    eq.push_back(x);
    if (gate) begin
      for (int i = 0; i < D; i++) mb[i] = 1'b0;
    end else begin
      if (x.iv && ir) begin
        iq.push_back('{tag: x.it, srcv: x.srcv});
        mb[sel] = 1'b0;
      end
      for (int i = 0; i < D; i++)
        for (int j = 0; j < NS; j++)
          if (cv && mb[i] && !mr[i][j] && mt[i][j] == ct) begin
            mr[i][j] = 1'b1;
            mv[i][j] = cval;
          end
      if (dv && fr >= 0) begin
        mb[fr] = 1'b1;
        ms[fr] = seq;
        seq++;
        mt[fr][0] = t0; mt[fr][1] = t1;
        mr[fr][0] = sr[0] || (cv && t0 == ct);
        mr[fr][1] = sr[1] || (cv && t1 == ct);
        mv[fr][0] = sr[0] ? v0 : cval;
        mv[fr][1] = sr[1] ? v1 : cval;
      end
    end
  endtask
  task automatic idle(input bit ir);
    cyc(0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, ir);
  endtask
  exp_t e;
  iss_t g;
  always @(negedge clk) begin
    #2;
    if (eq.size() > 0) begin
      e = eq.pop_front();
      chk("disp_ready", 64'(disp_ready), 64'(e.dr));
      if (e.chk_dt) chk("disp_tag", 64'(disp_tag), 64'(e.dt));
      chk("iss_valid", 64'(iss_valid), 64'(e.iv));
      chk("iss_tag", 64'(iss_tag), 64'(e.it));
      chk("iss_src", iss_src, e.srcv);
      chk("count", 64'(count), 64'(e.cnt));
      if (iss_valid && iss_ready) begin
        if (iq.size() == 0) chk("iss_unexpected", 64'(1), 64'(0));
        else begin
          g = iq.pop_front();
          chk("sb_tag", 64'(iss_tag), 64'(g.tag));
          chk("sb_src", iss_src, g.srcv);
        end
      end
    end
  end
  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_src_rdy = '0; disp_src_tag = '0;
    disp_src_val = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; iss_ready = 1'b0;
    repeat (2) @(negedge clk);
    cyc(1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 1, 2'b11, 8'h00, 8'h00, 5, 7, 0, 8'h00, 0, 1);
    idle(1);
    idle(1);
    cyc(0, 0, 1, 2'b10, 8'h41, 8'h00, 0, 3, 0, 8'h00, 0, 1);
    idle(1);
    cyc(0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 1, 8'h41, 100, 1);
    idle(1);
    idle(1);
    cyc(0, 0, 1, 2'b10, 8'h41, 8'h00, 0, 11, 1, 8'h41, 9, 1);
    idle(1);
    idle(1);
    for (int i = 0; i < D; i++) cyc(0, 0, 1, 2'b10, 8'(8'h50 + i), 8'h00, 0, 32'(i), 0, 8'h00, 0, 0);
    cyc(0, 0, 1, 2'b11, 8'h00, 8'h00, 1, 2, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 1, 8'h53, 33, 0);
    idle(1);
    cyc(0, 0, 1, 2'b11, 8'h00, 8'h00, 44, 45, 0, 8'h00, 0, 0);
    cyc(0, 1, 1, 2'b11, 8'h00, 8'h00, 1, 2, 1, 8'h50, 77, 1);
    idle(1);
    cyc(0, 0, 1, 2'b10, 8'h42, 8'h00, 0, 1, 0, 8'h00, 0, 0);
    cyc(0, 0, 1, 2'b11, 8'h00, 8'h00, 20, 21, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 1, 8'h42, 10, 0);
    idle(1);
    cyc(0, 0, 1, 2'b11, 8'h00, 8'h00, 30, 31, 0, 8'h00, 0, 0);
    idle(1);
    idle(1);
    idle(1);
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
          2'($urandom_range(0, 3)), ptag(), ptag(), $urandom, $urandom,
          $urandom_range(0, 1) == 1, ptag(), $urandom, $urandom_range(0, 2) != 0);
    idle(0);
    @(negedge clk);
    #5;
    chk("iss_queue_drained", 64'(iq.size()), 64'(0));
    chk("exp_queue_drained", 64'(eq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
